// File: rtl/branch_predictor.sv
// branch_predictor: bimodal table of 2-bit saturating counters beside Fetch (gshare indexing when GSHARE_EN is defined).
// Latency: PredictTakenF is combinational on PCF; Prediction appears one cycle later from the F->D register.
// Backpressure: StallD holds the F->D register and defers training until release; FlushD clears the register.

module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int PC_LSB     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        BranchD,
   input  logic        BranchTakenD,
   output logic        PredictTakenF,
   output logic        Prediction
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
   logic [1:0]            ctr [ENTRIES];

   logic [INDEX_BITS-1:0] pc_index;
   logic [INDEX_BITS-1:0] index_f;
   logic [INDEX_BITS-1:0] index_d;
   logic                  pred_d;
   logic                  valid_d;
   logic                  upd_d;
   logic [1:0]            ctr_cur;
   logic [1:0]            ctr_nxt;

   // Only the index field of PCF matters; the rest is deliberately ignored.
   logic                  unused_pc;
   assign unused_pc = ^PCF;

   assign pc_index = PCF[PC_LSB+INDEX_BITS-1 -: INDEX_BITS];

`ifdef GSHARE_EN
   logic [INDEX_BITS-1:0] ghr;

   // Global history shifts in each resolved outcome, once per branch leaving Decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         ghr <= '0;
      end else if (upd_d) begin
         ghr <= {ghr[INDEX_BITS-2:0], BranchTakenD};
      end
   end

   assign index_f = pc_index ^ ghr;
`else
   assign index_f = pc_index;
`endif

   // Fetch read sees the table as it stands this cycle; no bypass from a same-cycle update.
   assign PredictTakenF = ctr[index_f][1];

   // Train only when a real branch actually leaves Decode, so each branch updates exactly once.
   assign upd_d = valid_d & BranchD & ~StallD;

   // Bubbles and non-branches never report taken, so the hazard unit cannot flush on them.
   assign Prediction = pred_d & valid_d & BranchD;

   assign ctr_cur = ctr[index_d];

   // Saturating increment/decrement of the counter owned by the branch in Decode.
   always_comb begin
      ctr_nxt = ctr_cur;
      if (BranchTakenD) begin
         if (ctr_cur != 2'b11) begin
            ctr_nxt = ctr_cur + 2'd1;
         end
      end else begin
         if (ctr_cur != 2'b00) begin
            ctr_nxt = ctr_cur - 2'd1;
         end
      end
   end

   // Counter table: reset to weakly not-taken, then trained by resolved branches.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr[i] <= 2'b01;
         end
      end else if (upd_d) begin
         ctr[index_d] <= ctr_nxt;
      end
   end

   // F->D register: flush beats stall; the index kept is the one that produced the prediction.
   always_ff @(posedge clk) begin
      if (reset || FlushD) begin
         index_d <= '0;
         pred_d  <= 1'b0;
         valid_d <= 1'b0;
      end else if (!StallD) begin
         index_d <= index_f;
         pred_d  <= PredictTakenF;
         valid_d <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed literal checks plus randomized traffic against a behavioural model.
// The model keeps counters as plain integers clamped to 0..3 and a history value kept modulo 64.
// A negedge process compares both outputs against the model every cycle.

module tb_branch_predictor;

   localparam int IB = 6;
   localparam int NENT = 64;
`ifdef GSHARE_EN
   localparam bit GSH = 1'b1;
`else
   localparam bit GSH = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] PCF;
   logic        StallD;
   logic        FlushD;
   logic        BranchD;
   logic        BranchTakenD;
   logic        PredictTakenF;
   logic        Prediction;

   int checks;
   int failures;

   // Behavioural model state
   int mctr [NENT];
   int mghr;
   bit mvalid;
   int midx;
   bit mpred;
   bit model_ready;

   branch_predictor #(.INDEX_BITS(IB), .PC_LSB(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .PCF          (PCF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .BranchD      (BranchD),
      .BranchTakenD (BranchTakenD),
      .PredictTakenF(PredictTakenF),
      .Prediction   (Prediction)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int fidx(logic [31:0] pc);
      return ((pc / 4) % NENT) ^ mghr;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
      end
   endtask

   // Model advances on the same edge as the DUT, using the inputs held over that edge.
   always @(posedge clk) begin
      int fi;
      bit fp;
      bit upd;
      if (reset) begin
         for (int i = 0; i < NENT; i++) mctr[i] <= 1;
         mghr        <= 0;
         mvalid      <= 1'b0;
         midx        <= 0;
         mpred       <= 1'b0;
         model_ready <= 1'b1;
      end else if (model_ready) begin
         fi  = fidx(PCF);
         fp  = (mctr[fi] >= 2);
         upd = mvalid && BranchD && !StallD;
         if (upd) begin
            if (BranchTakenD) mctr[midx] <= (mctr[midx] < 3) ? mctr[midx] + 1 : 3;
            else              mctr[midx] <= (mctr[midx] > 0) ? mctr[midx] - 1 : 0;
            if (GSH) mghr <= (mghr * 2 + (BranchTakenD ? 1 : 0)) % NENT;
         end
         if (FlushD) begin
            mvalid <= 1'b0;
            midx   <= 0;
            mpred  <= 1'b0;
         end else if (!StallD) begin
            mvalid <= 1'b1;
            midx   <= fi;
            mpred  <= fp;
         end
      end
   end

   // Every-cycle comparison of both outputs against the model.
   always @(negedge clk) begin
      if (model_ready) begin
         chk("model_PredictTakenF", PredictTakenF, (mctr[fidx(PCF)] >= 2));
         chk("model_Prediction", Prediction, mpred && mvalid && BranchD);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      StallD = 1'b0; FlushD = 1'b0; BranchD = 1'b0; BranchTakenD = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      step();
      step();
      reset = 1'b0;
   endtask

   // Fetch pc, then resolve it in Decode next cycle; the update lands on the following edge.
   task automatic branch_at(input logic [31:0] pc, input logic taken);
      idle();
      PCF = pc;
      step();
      BranchD = 1'b1;
      BranchTakenD = taken;
      PCF = 32'h200;
      step();
      idle();
   endtask

   task automatic peek(input string name, input logic [31:0] pc, input logic exp);
      BranchD = 1'b0;
      PCF = pc;
      #1;
      chk(name, PredictTakenF, exp);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      model_ready = 1'b0;
      mghr = 0;
      reset = 1'b1;
      PCF = 32'h0;
      idle();
      do_reset();

      // Reset state: bubble in Decode, all counters weakly not-taken
      BranchD = 1'b1;
      #1;
      chk("reset_Prediction", Prediction, 1'b0);
      BranchD = 1'b0;
      for (int pc = 0; pc <= 32'hFC; pc += 4) begin
         PCF = pc;
         #1;
         chk("reset_sweep_PredictTakenF", PredictTakenF, 1'b0);
         step();
      end

`ifndef GSHARE_EN
      // Train taken at 0x40 (index 16): 01->10->11
      branch_at(32'h40, 1'b1);
      peek("train_taken_1", 32'h40, 1'b1);
      branch_at(32'h40, 1'b1);
      peek("train_taken_2", 32'h40, 1'b1);
      // Saturate at 11, then walk down to 00
      for (int k = 0; k < 3; k++) branch_at(32'h40, 1'b1);
      branch_at(32'h40, 1'b0);
      peek("sat_hi_nt1", 32'h40, 1'b1);
      branch_at(32'h40, 1'b0);
      peek("sat_hi_nt2", 32'h40, 1'b0);
      branch_at(32'h40, 1'b0);
      branch_at(32'h40, 1'b0);
      // From 00: one taken gives 01 (still NT), second gives 10
      branch_at(32'h40, 1'b1);
      peek("sat_lo_t1", 32'h40, 1'b0);
      branch_at(32'h40, 1'b1);
      peek("sat_lo_t2", 32'h40, 1'b1);

      // Stall: branch at 0x80 (index 32, 01) held in Decode for 3 cycles
      idle();
      PCF = 32'h80;
      step();
      BranchD = 1'b1; BranchTakenD = 1'b1; StallD = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_no_update", PredictTakenF, 1'b0);
         chk("stall_pred_stable", Prediction, 1'b0);
         step();
      end
      StallD = 1'b0;
      step();
      idle();
      peek("stall_release_inc", 32'h80, 1'b1);
      branch_at(32'h80, 1'b0);
      peek("stall_single_inc", 32'h80, 1'b0);

      // Flush with stall: capture a taken prediction from 0x40 (ctr=10), then flush it
      idle();
      PCF = 32'h40;
      step();
      BranchD = 1'b1; BranchTakenD = 1'b0; StallD = 1'b1;
      #1;
      chk("flush_pre_pred", Prediction, 1'b1);
      FlushD = 1'b1;
      step();
      FlushD = 1'b0;
      #1;
      chk("flush_clears_pred", Prediction, 1'b0);
      idle();
      step();

      // Non-branch masking: PredD=1 captured but BranchD=0
      PCF = 32'h40;
      step();
      BranchD = 1'b0; BranchTakenD = 1'b0;
      #1;
      chk("nonbranch_pred_masked", Prediction, 1'b0);
      step();
      peek("nonbranch_no_update", 32'h40, 1'b1);
`else
      // History T,T,NT -> 0b000110
      branch_at(32'h0, 1'b1);
      branch_at(32'h0, 1'b1);
      branch_at(32'h0, 1'b0);
      chk("model_ghr_is_6", (mghr == 6), 1'b1);
      peek("gshare_idx22_initial", 32'h40, 1'b0);
      branch_at(32'h40, 1'b1);
      // ghr now 13: PC 0x6C (27) ^ 13 = 22 sees the trained entry; 0x40 now maps to 29
      peek("gshare_idx22_trained", 32'h6C, 1'b1);
      peek("gshare_pc40_moved", 32'h40, 1'b0);
`endif

      // Randomized traffic against the model
      idle();
      for (int n = 0; n < 3000; n++) begin
         PCF          = ($urandom_range(0, 7) * 4) | ($urandom_range(0, 1) << 8);
         BranchD      = $urandom_range(0, 1);
         BranchTakenD = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         StallD       = ($urandom_range(0, 4) == 0);
         FlushD       = ($urandom_range(0, 9) == 0);
         reset        = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 1'b0;
      idle();
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
